// File: rtl/l1_snoop_responder.sv
// MESI snoop responder beside an L1 data cache: arbitrates for the shared tag port,
// reports the line's coherence status to the bus and applies the downgrade or invalidate.
module l1_snoop_responder #(
  parameter int ADDR_W     = 32,
  parameter int BLOCK_SIZE = 2,
  parameter int SETS       = 64
) (
  input  logic                                             CLK,
  input  logic                                             RST,
  input  logic                                             ccwait,
  input  logic                                             ccinv,
  input  logic [ADDR_W-1:0]                                ccsnoopaddr,
  output logic                                             ccsnoopdone,
  output logic                                             ccIsPresent,
  output logic                                             ccsnoophit,
  output logic                                             ccdirty,
  output logic [BLOCK_SIZE*32-1:0]                         dstore,
  input  logic                                             cache_busy,
  output logic                                             snoop_busy,
  output logic                                             tag_rd_en,
  output logic [$clog2(SETS)-1:0]                          tag_rd_idx,
  input  logic [ADDR_W-$clog2(BLOCK_SIZE)-2-$clog2(SETS)-1:0] tag_rd_tag,
  input  logic [1:0]                                       tag_rd_state,
  input  logic [BLOCK_SIZE*32-1:0]                         tag_rd_data,
  output logic                                             st_wen,
  output logic [$clog2(SETS)-1:0]                          st_idx,
  output logic [1:0]                                       st_state
);
  localparam int OFF   = $clog2(BLOCK_SIZE) + 2;
  localparam int IDX   = $clog2(SETS);
  localparam int TAG_W = ADDR_W - OFF - IDX;

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] ARB     = 3'd1;
  localparam logic [2:0] READ    = 3'd2;
  localparam logic [2:0] COMPARE = 3'd3;
  localparam logic [2:0] RESPOND = 3'd4;
  localparam logic [2:0] UPDATE  = 3'd5;

  localparam logic [1:0] ST_I = 2'd0;
  localparam logic [1:0] ST_S = 2'd1;
  localparam logic [1:0] ST_M = 2'd3;

  logic [2:0]              state, nxt;
  logic [IDX-1:0]          idx_q;
  logic [TAG_W-1:0]        tag_q;
  logic                    inv_q;
  logic                    present_q;
  logic [1:0]              line_q;
  logic [BLOCK_SIZE*32-1:0] data_q;

  // Block-offset bits carry no information for a block-aligned snoop.
  logic unused_off;
  assign unused_off = ^ccsnoopaddr[OFF-1:0];

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (ccwait) nxt = cache_busy ? ARB : READ;
      ARB:     if (!ccwait) nxt = IDLE;
               else if (!cache_busy) nxt = READ;
      READ:    nxt = ccwait ? COMPARE : IDLE;
      COMPARE: nxt = ccwait ? RESPOND : IDLE;
      RESPOND: if (!ccwait) nxt = present_q ? UPDATE : IDLE;
      UPDATE:  nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      idx_q     <= '0;
      tag_q     <= '0;
      inv_q     <= 1'b0;
      present_q <= 1'b0;
      line_q    <= ST_I;
      data_q    <= '0;
    end else begin
      state <= nxt;
      case (state)
        IDLE: if (ccwait) begin
          {tag_q, idx_q} <= ccsnoopaddr[ADDR_W-1:OFF];
          inv_q          <= ccinv;
        end
        ARB, READ, RESPOND: inv_q <= inv_q | ccinv;
        COMPARE: begin
          inv_q <= inv_q | ccinv;
          if (ccwait) begin
            present_q <= (tag_rd_state != ST_I) && (tag_rd_tag == tag_q);
            line_q    <= tag_rd_state;
            data_q    <= tag_rd_data;
          end
        end
        default: ;
      endcase
      // Every path back to IDLE leaves the responder fully quiet.
      if (nxt == IDLE && state != IDLE) begin
        idx_q     <= '0;
        tag_q     <= '0;
        inv_q     <= 1'b0;
        present_q <= 1'b0;
        line_q    <= ST_I;
        data_q    <= '0;
      end
    end
  end

  assign ccsnoopdone = (state == RESPOND);
  assign ccIsPresent = present_q;
  assign ccsnoophit  = present_q && line_q[1];
  assign ccdirty     = present_q && (line_q == ST_M);
  assign dstore      = data_q;
  assign snoop_busy  = (state != IDLE);
  assign tag_rd_en   = (state == READ);
  assign tag_rd_idx  = tag_rd_en ? idx_q : '0;
  assign st_wen      = (state == UPDATE);
  assign st_idx      = st_wen ? idx_q : '0;
  assign st_state    = (st_wen && !inv_q) ? ST_S : ST_I;
endmodule

// File: doc/l1_snoop_responder.md
Name: l1_snoop_responder

Overview:
- Cache-side responder of the MESI coherence bus. One instance sits beside each L1 data cache.
- Accepts snoop requests (ccwait, ccinv, ccsnoopaddr) from the bus controller and looks up the cache's tag/state array through a shared one-cycle read port.
- Reports presence, ownership and dirtiness, and supplies the block on a hit.
- Applies the MESI downgrade or invalidate once the bus releases the snoop.

Parameters:
- ADDR_W, 32, address width.
- BLOCK_SIZE, 2, words (32-bit) per cache block.
- SETS, 64, direct-mapped sets. Power of two.

Ports:
- CLK  in  1  clock.
- RST  in  1  synchronous active-high reset.
- ccwait  in  1  snoop request held by the bus.
- ccinv  in  1  invalidate qualifier.
- ccsnoopaddr  in  ADDR_W  block-aligned snoop address.
- ccsnoopdone  out  1  lookup complete, result valid.
- ccIsPresent  out  1  line valid in S/E/M.
- ccsnoophit  out  1  line held in E or M; this cache supplies data.
- ccdirty  out  1  line held in M.
- dstore  out  BLOCK_SIZE*32  supplied block.
- cache_busy  in  1  cache pipeline owns the tag port this cycle.
- snoop_busy  out  1  responder active; cache blocks its own state writes.
- tag_rd_en  out  1  tag/data read request.
- tag_rd_idx  out  log2(SETS)  read index.
- tag_rd_tag  in  ADDR_W-OFF-IDX  tag returned one cycle after tag_rd_en.
- tag_rd_state  in  2  MESI state returned: I=0, S=1, E=2, M=3.
- tag_rd_data  in  BLOCK_SIZE*32  block returned.
- st_wen  out  1  state write strobe.
- st_idx  out  log2(SETS)  state write index.
- st_state  out  2  new MESI state.

Behaviour:
- Reset and clocking: one clock. Reset is synchronous and active-high. RST high at a CLK edge forces state IDLE and clears every output and internal register to 0, including mid-operation; no state write is issued.
- Address decode: OFF = log2(BLOCK_SIZE)+2, IDX = log2(SETS). index = addr[OFF+IDX-1:OFF], tag = addr[ADDR_W-1:OFF+IDX].
- FSM states: IDLE, ARB, READ, COMPARE, RESPOND, UPDATE.
- IDLE:
  - On ccwait=1, latch ccsnoopaddr and ccinv.
  - Go to READ if cache_busy=0, else to ARB.
- ARB: stay while cache_busy=1; go to READ when it is 0.
- READ:
  - tag_rd_en=1 and tag_rd_idx=index, both combinational, for exactly one cycle.
  - Go to COMPARE.
- COMPARE:
  - Register present = (tag_rd_state!=I) && (tag_rd_tag==tag), hit = present && state in {E,M}, dirty = present && state==M, dstore = tag_rd_data.
  - Also register the looked-up state.
  - Go to RESPOND.
- RESPOND:
  - ccsnoopdone=1 and ccIsPresent/ccsnoophit/ccdirty/dstore driven from registers, all held stable.
  - If ccinv is seen high in any cycle from IDLE through RESPOND, the latched inv flag is set; it is never cleared until IDLE.
  - When ccwait=0: go to UPDATE if present, else to IDLE.
- UPDATE:
  - st_wen=1 and st_idx=index for one cycle.
  - st_state = I if inv, else S (M, E and S all become S).
  - Go to IDLE.
- Output clearing: outputs clear to 0 on entry to IDLE.
- Latency: ccwait sampled at edge N with cache_busy=0 gives READ after N, COMPARE after N+1, and ccsnoopdone high from edge N+2. Each ARB cycle adds one cycle.
- snoop_busy = 1 in every state except IDLE.
- Abort: if ccwait drops in ARB, READ or COMPARE, the lookup is abandoned and the state goes to IDLE next edge. No state write. ccsnoopdone is never asserted.
- Simultaneous events: ccwait falling in the same cycle RESPOND is entered is taken as release, so UPDATE follows directly.
- Back-to-back snoops: the first cycle back in IDLE may accept a new ccwait.

Test Plan:
- Read snoop, M hit: index 5 holds tag 0x1234 in M, data 0xAAAA_BBBB_CCCC_DDDD; ccwait=1, ccinv=0 → ccsnoopdone at N+2 with hit=1, present=1, dirty=1, dstore=data. On ccwait=0: st_wen at idx 5 with st_state=S.
- RX snoop, S hit: ccwait=1, ccinv=1, line in S → present=1, hit=0, dirty=0. After release, st_state=I.
- Miss: tag mismatch, or state I with matching tag → done with all flags 0. No st_wen after release.
- cache_busy held for 3 cycles at request → ARB for 3 cycles, tag_rd_en exactly once, ccsnoopdone at N+5.
- Late ccinv: read snoop in E, ccinv rises during RESPOND → release writes I, not S.
- Abort and reset:
  - ccwait dropped in READ → no ccsnoopdone, no st_wen, IDLE the next cycle.
  - RST during RESPOND → all outputs 0 the next cycle, no st_wen.
